// File: rtl/shifter_pkg.sv
// Shared types, widths and helpers for the bitplane shifter.
// Define PLANE8_EN to build 8-plane storage and enable mode 3 as 8 planes.
package shifter_pkg;

    localparam int WORD_W = 16;
    localparam int IDX_W  = 8;
    localparam int CNT_W  = 5;

`ifdef PLANE8_EN
    localparam int PLANES_MAX = 8;
`else
    localparam int PLANES_MAX = 4;
`endif

    localparam logic [1:0] MODE_4P = 2'd0;
    localparam logic [1:0] MODE_2P = 2'd1;
    localparam logic [1:0] MODE_1P = 2'd2;
    localparam logic [1:0] MODE_8P = 2'd3;

    typedef enum logic {
        SH_EMPTY = 1'b0,
        SH_RUN   = 1'b1
    } shift_state_e;

    // Number of plane words that make up one 16-pixel group.
    function automatic logic [3:0] planes_for_mode(input logic [1:0] mode);
        logic [3:0] n;
        case (mode)
            MODE_4P: n = 4'd4;
            MODE_2P: n = 4'd2;
            MODE_1P: n = 4'd1;
`ifdef PLANE8_EN
            MODE_8P: n = 4'd8;
`else
            MODE_8P: n = 4'd1;
`endif
            default: n = 4'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/plane_buffer.sv
// Group loader: collects N plane words into one buffer slot set and flags FULL.
// Mode is sampled on the first word of a group and held until the group completes.
module plane_buffer
    import shifter_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [1:0]                          mode,
    input  logic [WORD_W-1:0]                   in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                take,
    output logic                                full,
    output logic [PLANES_MAX-1:0][WORD_W-1:0]   planes,
    output logic [3:0]                          n_planes
);

    logic [3:0] wcnt;
    logic [3:0] n_eff;
    logic       accept;

    // Handshake: a word transfers on a rising clk where in_valid && in_ready;
    // in_ready depends only on buffer state, never on in_valid.
    assign in_ready = !full;
    assign accept   = in_valid && in_ready && !flush;
    assign n_eff    = (wcnt == 4'd0) ? planes_for_mode(mode) : n_planes;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full     <= 1'b0;
            wcnt     <= 4'd0;
            n_planes <= 4'd1;
            planes   <= '0;
        end else if (flush) begin
            full <= 1'b0;
            wcnt <= 4'd0;
        end else begin
            // take is only raised while full, so it never meets an accept
            if (take)
                full <= 1'b0;
            if (accept) begin
                if (wcnt == 4'd0)
                    n_planes <= n_eff;
                for (int k = 0; k < PLANES_MAX; k++) begin
                    if (wcnt == 4'(k))
                        planes[k] <= in_data;
                end
                if (wcnt + 4'd1 == n_eff) begin
                    full <= 1'b1;
                    wcnt <= 4'd0;
                end else begin
                    wcnt <= wcnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/plane_shifter.sv
// Bitplane-to-pixel serializer: double-buffered group loader plus shift/count FSM.
// Build with PLANE8_EN for 8-plane storage (mode 3 = 8 planes); otherwise 4 planes.
module plane_shifter
    import shifter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic               flush,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               pix_en,
    output logic [IDX_W-1:0]   pix_idx,
    output logic               pix_valid,
    output logic               underrun,
    output shift_state_e       state_dbg
);

    shift_state_e                       state_q, state_d;
    logic [PLANES_MAX-1:0][WORD_W-1:0]  sh_q;
    logic [PLANES_MAX-1:0][WORD_W-1:0]  buf_planes;
    logic [3:0]                         n_q;
    logic [3:0]                         buf_n;
    logic [CNT_W-1:0]                   cnt_q;
    logic                               buf_full;
    logic                               load;
    logic                               last_pix;
    logic [IDX_W-1:0]                   idx_next;

    plane_buffer u_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .mode     (mode),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .take     (load),
        .full     (buf_full),
        .planes   (buf_planes),
        .n_planes (buf_n)
    );

    assign last_pix  = pix_en && (cnt_q == CNT_W'(1));
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            SH_EMPTY: begin
                if (buf_full) begin
                    load    = 1'b1;
                    state_d = SH_RUN;
                end
            end
            SH_RUN: begin
                // Reload on the 16th pixel keeps back-to-back groups bubble-free
                if (last_pix) begin
                    if (buf_full)
                        load = 1'b1;
                    else
                        state_d = SH_EMPTY;
                end
            end
            default: state_d = SH_EMPTY;
        endcase
        if (flush) begin
            state_d = SH_EMPTY;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= SH_EMPTY;
        else
            state_q <= state_d;
    end

    // Planes beyond the latched count contribute zero index bits.
    always_comb begin
        idx_next = '0;
        for (int k = 0; k < PLANES_MAX; k++) begin
            if (4'(k) < n_q)
                idx_next[k] = sh_q[k][WORD_W-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q      <= '0;
            n_q       <= 4'd1;
            cnt_q     <= '0;
            pix_idx   <= '0;
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
        end else if (flush) begin
            cnt_q     <= '0;
            pix_idx   <= '0;
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
            if (state_q == SH_RUN && pix_en) begin
                pix_idx   <= idx_next;
                pix_valid <= 1'b1;
                cnt_q     <= cnt_q - CNT_W'(1);
                for (int k = 0; k < PLANES_MAX; k++)
                    sh_q[k] <= {sh_q[k][WORD_W-2:0], 1'b0};
            end else if (state_q == SH_EMPTY && pix_en) begin
                pix_idx  <= '0;
                underrun <= 1'b1;
            end
            if (load) begin
                sh_q  <= buf_planes;
                n_q   <= buf_n;
                cnt_q <= CNT_W'(WORD_W);
            end
        end
    end

endmodule

// File: tb/tb_plane_shifter.sv
// Directed bench for plane_shifter: fill, steady-state, mode latch, flush and 8-plane cases.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_plane_shifter;
    import shifter_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         mode;
    logic               flush;
    logic [WORD_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic               pix_en;
    logic [IDX_W-1:0]   pix_idx;
    logic               pix_valid;
    logic               underrun;
    shift_state_e       state_dbg;

    int tests_run = 0;
    int tests_failed = 0;

    plane_shifter dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pix_en    (pix_en),
        .pix_idx   (pix_idx),
        .pix_valid (pix_valid),
        .underrun  (underrun),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [WORD_W-1:0] w);
        in_data  = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    logic [WORD_W-1:0] a0, a1, b0, b1;
    logic [IDX_W-1:0]  exp_idx;

    initial begin
        reset = 1'b1; mode = MODE_4P; flush = 1'b0;
        in_data = '0; in_valid = 1'b0; pix_en = 1'b0;
        step(); step();
        check("rst_pix_idx", 32'(pix_idx), 32'h0);
        check("rst_pix_valid", 32'(pix_valid), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_state", 32'(state_dbg), 32'(SH_EMPTY));
        reset = 1'b0;
        step();

        // 1-plane group 8001: pixels 1, 0 x14, 1 then an underrun
        mode = MODE_1P;
        feed(16'h8001);
        check("m2_full_ready", 32'(in_ready), 32'h0);
        step();
        check("m2_loaded_ready", 32'(in_ready), 32'h1);
        check("m2_loaded_state", 32'(state_dbg), 32'(SH_RUN));
        pix_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check("m2_valid", 32'(pix_valid), 32'h1);
            check("m2_idx", 32'(pix_idx), (i == 0 || i == 15) ? 32'h1 : 32'h0);
        end
        step();
        check("m2_underrun", 32'(underrun), 32'h1);
        check("m2_under_valid", 32'(pix_valid), 32'h0);
        check("m2_under_idx", 32'(pix_idx), 32'h0);
        pix_en = 1'b0;
        step();
        check("m2_underrun_pulse", 32'(underrun), 32'h0);

        // 4-plane group FFFF/0000/FFFF/0000 gives index 05 for every pixel
        mode = MODE_4P;
        feed(16'hFFFF); check("m0_ready_w1", 32'(in_ready), 32'h1);
        feed(16'h0000); check("m0_ready_w2", 32'(in_ready), 32'h1);
        feed(16'hFFFF); check("m0_ready_w3", 32'(in_ready), 32'h1);
        feed(16'h0000); check("m0_ready_w4", 32'(in_ready), 32'h0);
        step();
        pix_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check("m0_valid", 32'(pix_valid), 32'h1);
            check("m0_idx", 32'(pix_idx), 32'h05);
        end
        pix_en = 1'b0;
        step();
        check("m0_idle_valid", 32'(pix_valid), 32'h0);
        check("m0_idle_idx_hold", 32'(pix_idx), 32'h05);

        // Two preloaded 2-plane groups stream 32 pixels with no gap
        mode = MODE_2P;
        a0 = 16'hAAAA; a1 = 16'h0F0F; b0 = 16'h1234; b1 = 16'hFFFF;
        feed(a0); feed(a1);
        step();
        feed(b0); feed(b1);
        check("m1_second_full", 32'(in_ready), 32'h0);
        pix_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            if (i < 16) exp_idx = {6'd0, a1[15-i], a0[15-i]};
            else        exp_idx = {6'd0, b1[31-i], b0[31-i]};
            check("m1_valid", 32'(pix_valid), 32'h1);
            check("m1_no_underrun", 32'(underrun), 32'h0);
            check("m1_idx", 32'(pix_idx), 32'(exp_idx));
        end
        step();
        check("m1_tail_underrun", 32'(underrun), 32'h1);
        pix_en = 1'b0;
        step();

        // Mode change mid-group is ignored; next group uses the new mode
        mode = MODE_4P;
        feed(16'h8000); feed(16'h0000);
        mode = MODE_1P;
        feed(16'h0000);
        check("ml_still_open", 32'(in_ready), 32'h1);
        feed(16'h8000);
        check("ml_full_after4", 32'(in_ready), 32'h0);
        step();
        feed(16'hFFFF);
        check("ml_next_1word", 32'(in_ready), 32'h0);
        pix_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            if (i < 16) exp_idx = (i == 0) ? 8'h09 : 8'h00;
            else        exp_idx = 8'h01;
            check("ml_valid", 32'(pix_valid), 32'h1);
            check("ml_idx", 32'(pix_idx), 32'(exp_idx));
        end
        pix_en = 1'b0;
        step();

        // Flush on pixel 7 with a partial next group and a word on the bus
        mode = MODE_1P;
        feed(16'h5555);
        step();
        mode = MODE_4P;
        feed(16'h1111); feed(16'h2222);
        pix_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check("fl_idx", 32'(pix_idx), (i % 2 == 0) ? 32'h0 : 32'h1);
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 16'h3333;
        step();
        flush = 1'b0; in_valid = 1'b0; pix_en = 1'b0;
        check("fl_valid", 32'(pix_valid), 32'h0);
        check("fl_idx_zero", 32'(pix_idx), 32'h0);
        check("fl_ready", 32'(in_ready), 32'h1);
        check("fl_state", 32'(state_dbg), 32'(SH_EMPTY));
        pix_en = 1'b1;
        step();
        check("fl_underrun", 32'(underrun), 32'h1);
        pix_en = 1'b0;
        step();
        check("fl_underrun_pulse", 32'(underrun), 32'h0);
        feed(16'h0001); feed(16'h0002); feed(16'h0003);
        check("fl_count_cleared", 32'(in_ready), 32'h1);
        feed(16'h0004);
        check("fl_refill_full", 32'(in_ready), 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_clear_again", 32'(in_ready), 32'h1);

        // Mode 3: 8 planes of 8000 with PLANE8_EN, otherwise a single plane
        mode = MODE_8P;
`ifdef PLANE8_EN
        for (int k = 0; k < 8; k++) feed(16'h8000);
        exp_idx = 8'hFF;
`else
        feed(16'h8000);
        exp_idx = 8'h01;
`endif
        check("m3_full", 32'(in_ready), 32'h0);
        step();
        pix_en = 1'b1;
        step();
        check("m3_first_idx", 32'(pix_idx), 32'(exp_idx));
        step();
        check("m3_second_idx", 32'(pix_idx), 32'h00);
        pix_en = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
